// File: rtl/enc_multi_decoder.sv
// ----------------------------------------------------------------------------
// enc_multi_decoder
//   Multi-channel quadrature encoder decoder for Pmod ENC style knobs.
//   Each channel synchronises and debounces its raw A/B pins, decodes the
//   rotation direction in x1 (detent) or x4 (every edge) mode, emits one-cycle
//   cw/ccw/err pulses and keeps a signed position count that wraps or saturates.
//
// Parameters
//   NUM_CH   : number of independent channels (>=1)
//   COUNT_W  : width of each signed position counter (>=2)
//   DEBOUNCE : consecutive stable cycles before a filtered input changes (>=1)
//   MODE     : 0 = x1 (one step per full detent), 1 = x4 (every legal edge)
//   WRAP     : 1 = two's-complement wrap, 0 = saturate at the limits
//
// Ports
//   clk      in   1                system clock, rising edge
//   rst      in   1                asynchronous active-high reset
//   A, B     in   NUM_CH           raw encoder pins, asynchronous to clk
//   clear    in   NUM_CH           synchronous clear of a channel's count
//   dir_cw   out  NUM_CH           one-cycle pulse per clockwise step
//   dir_ccw  out  NUM_CH           one-cycle pulse per counter-clockwise step
//   err      out  NUM_CH           one-cycle pulse when A and B change together
//   count    out  NUM_CH*COUNT_W   signed counts, channel i at [i*COUNT_W +: COUNT_W]
// ----------------------------------------------------------------------------
module enc_multi_decoder #(
   parameter int unsigned NUM_CH   = 2,
   parameter int unsigned COUNT_W  = 8,
   parameter int unsigned DEBOUNCE = 16,
   parameter int unsigned MODE     = 0,
   parameter int unsigned WRAP     = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_CH-1:0]         A,
   input  logic [NUM_CH-1:0]         B,
   input  logic [NUM_CH-1:0]         clear,
   output logic [NUM_CH-1:0]         dir_cw,
   output logic [NUM_CH-1:0]         dir_ccw,
   output logic [NUM_CH-1:0]         err,
   output logic [NUM_CH*COUNT_W-1:0] count
);

   // Debounce counter only has to reach DEBOUNCE-1.
   localparam int unsigned        DB_W    = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
   localparam logic [DB_W-1:0]    DB_LAST = DB_W'(DEBOUNCE - 1);
   localparam logic [COUNT_W-1:0] CNT_MAX = {1'b0, {(COUNT_W-1){1'b1}}};
   localparam logic [COUNT_W-1:0] CNT_MIN = {1'b1, {(COUNT_W-1){1'b0}}};
   localparam logic [1:0]         AB_IDLE = 2'b11;

   // Per-channel {A,B} pairs: bit 1 = A, bit 0 = B.
   logic [NUM_CH-1:0][1:0]            sync1_q, sync1_d;
   logic [NUM_CH-1:0][1:0]            sync2_q, sync2_d;
   logic [NUM_CH-1:0][1:0]            filt_q,  filt_d;
   logic [NUM_CH-1:0][1:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
   logic [NUM_CH-1:0][1:0]            prev_q,  prev_d;
   logic [NUM_CH-1:0][2:0]            sub_q,   sub_d;
   logic [NUM_CH-1:0][COUNT_W-1:0]    cnt_q,   cnt_d;
   logic [NUM_CH-1:0]                 cw_q,  cw_d;
   logic [NUM_CH-1:0]                 ccw_q, ccw_d;
   logic [NUM_CH-1:0]                 err_q, err_d;
   logic [NUM_CH-1:0]                 inc_c, dec_c;

   // Position of a Gray state along the CW sequence 11 -> 01 -> 00 -> 10.
   function automatic logic [1:0] gray_pos(input logic [1:0] ab);
      case (ab)
         2'b11:   gray_pos = 2'd0;
         2'b01:   gray_pos = 2'd1;
         2'b00:   gray_pos = 2'd2;
         default: gray_pos = 2'd3;
      endcase
   endfunction

   // Two-stage synchroniser on every raw pin.
   always_comb begin : sync_comb
      sync1_d = sync1_q;
      sync2_d = sync2_q;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         sync1_d[ch] = {A[ch], B[ch]};
         sync2_d[ch] = sync1_q[ch];
      end
   end

   // Per-bit debounce: filtered bit follows only after DEBOUNCE mismatching edges in a row.
   always_comb begin : debounce_comb
      filt_d   = filt_q;
      db_cnt_d = db_cnt_q;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         for (int b = 0; b < 2; b++) begin
            if (sync2_q[ch][b] == filt_q[ch][b]) begin
               db_cnt_d[ch][b] = '0;
            end else if (db_cnt_q[ch][b] == DB_LAST) begin
               filt_d[ch][b]   = sync2_q[ch][b];
               db_cnt_d[ch][b] = '0;
            end else begin
               db_cnt_d[ch][b] = db_cnt_q[ch][b] + DB_W'(1);
            end
         end
      end
   end

   // Direction decode of prev -> filtered state; x1 accumulates sub-steps until 11 is re-entered.
   always_comb begin : decode_comb
      logic [1:0] delta;
      logic [3:0] sum;
      delta  = '0;
      sum    = '0;
      prev_d = filt_q;
      sub_d  = sub_q;
      inc_c  = '0;
      dec_c  = '0;
      err_d  = '0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         delta = gray_pos(filt_q[ch]) - gray_pos(prev_q[ch]);
         if (delta == 2'd2) begin
            // Both bits moved at once: direction unknown, drop partial progress.
            err_d[ch] = 1'b1;
            sub_d[ch] = '0;
         end else if (delta != 2'd0) begin
            if (MODE != 0) begin
               inc_c[ch] = (delta == 2'd1);
               dec_c[ch] = (delta == 2'd3);
            end else begin
               // Sign-extend to 4 bits so a full detent (+/-4) is representable.
               sum = {sub_q[ch][2], sub_q[ch]} + ((delta == 2'd1) ? 4'b0001 : 4'b1111);
               if (filt_q[ch] == AB_IDLE) begin
                  inc_c[ch] = (sum == 4'b0100);
                  dec_c[ch] = (sum == 4'b1100);
                  sub_d[ch] = '0;
               end else begin
                  sub_d[ch] = sum[2:0];
               end
            end
         end
      end
   end

   // Position counter with wrap/saturate; clear overrides a coincident step.
   always_comb begin : count_comb
      cnt_d = cnt_q;
      cw_d  = inc_c;
      ccw_d = dec_c;
      for (int ch = 0; ch < NUM_CH; ch++) begin
         if (inc_c[ch]) begin
            if ((WRAP != 0) || (cnt_q[ch] != CNT_MAX)) begin
               cnt_d[ch] = cnt_q[ch] + COUNT_W'(1);
            end
         end else if (dec_c[ch]) begin
            if ((WRAP != 0) || (cnt_q[ch] != CNT_MIN)) begin
               cnt_d[ch] = cnt_q[ch] - COUNT_W'(1);
            end
         end
         if (clear[ch]) begin
            cnt_d[ch] = '0;
         end
      end
   end

   // State registers; reset parks every channel at idle 11 with nothing pending.
   always_ff @(posedge clk or posedge rst) begin : state_ff
      if (rst) begin
         sync1_q  <= '1;
         sync2_q  <= '1;
         filt_q   <= '1;
         db_cnt_q <= '0;
         prev_q   <= '1;
         sub_q    <= '0;
         cnt_q    <= '0;
         cw_q     <= '0;
         ccw_q    <= '0;
         err_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         filt_q   <= filt_d;
         db_cnt_q <= db_cnt_d;
         prev_q   <= prev_d;
         sub_q    <= sub_d;
         cnt_q    <= cnt_d;
         cw_q     <= cw_d;
         ccw_q    <= ccw_d;
         err_q    <= err_d;
      end
   end

   assign dir_cw  = cw_q;
   assign dir_ccw = ccw_q;
   assign err     = err_q;
   assign count   = cnt_q;

endmodule

// File: tb/tb_enc_multi_decoder.sv
// ----------------------------------------------------------------------------
// tb_enc_multi_decoder
//   Directed bench for enc_multi_decoder with DEBOUNCE=4 and two channels.
//   Three instances share stimulus: x1/wrap (w_*), x1/saturate (s_*), x4/wrap (f_*).
//   Inputs change 1 time unit after a rising edge; outputs are read there too.
// ----------------------------------------------------------------------------
module tb_enc_multi_decoder;

   localparam int DB   = 4;
   localparam int HOLD = 20;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  A, B, clear;

   logic [1:0]  w_cw, w_ccw, w_err;
   logic [15:0] w_cnt;
   logic [1:0]  s_cw, s_ccw, s_err;
   logic [15:0] s_cnt;
   logic [1:0]  f_cw, f_ccw, f_err;
   logic [15:0] f_cnt;

   int checks = 0;
   int errors = 0;

   // Running pulse tallies, sampled on the falling edge.
   int n_w_cw[2], n_w_ccw[2], n_w_err[2];
   int n_s_cw[2];
   int n_f_cw[2], n_f_ccw[2], n_f_err[2];

   always #5 clk = ~clk;

   enc_multi_decoder #(.NUM_CH(2), .COUNT_W(8), .DEBOUNCE(DB), .MODE(0), .WRAP(1)) u_x1_wrap (
      .clk(clk), .rst(rst), .A(A), .B(B), .clear(clear),
      .dir_cw(w_cw), .dir_ccw(w_ccw), .err(w_err), .count(w_cnt));

   enc_multi_decoder #(.NUM_CH(2), .COUNT_W(8), .DEBOUNCE(DB), .MODE(0), .WRAP(0)) u_x1_sat (
      .clk(clk), .rst(rst), .A(A), .B(B), .clear(clear),
      .dir_cw(s_cw), .dir_ccw(s_ccw), .err(s_err), .count(s_cnt));

   enc_multi_decoder #(.NUM_CH(2), .COUNT_W(8), .DEBOUNCE(DB), .MODE(1), .WRAP(1)) u_x4_wrap (
      .clk(clk), .rst(rst), .A(A), .B(B), .clear(clear),
      .dir_cw(f_cw), .dir_ccw(f_ccw), .err(f_err), .count(f_cnt));

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (w_cw[i]  === 1'b1) n_w_cw[i]  <= n_w_cw[i]  + 1;
         if (w_ccw[i] === 1'b1) n_w_ccw[i] <= n_w_ccw[i] + 1;
         if (w_err[i] === 1'b1) n_w_err[i] <= n_w_err[i] + 1;
         if (s_cw[i]  === 1'b1) n_s_cw[i]  <= n_s_cw[i]  + 1;
         if (f_cw[i]  === 1'b1) n_f_cw[i]  <= n_f_cw[i]  + 1;
         if (f_ccw[i] === 1'b1) n_f_ccw[i] <= n_f_ccw[i] + 1;
         if (f_err[i] === 1'b1) n_f_err[i] <= n_f_err[i] + 1;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive(input int ch, input logic [1:0] ab, input int hold);
      A[ch] = ab[1];
      B[ch] = ab[0];
      tick(hold);
   endtask

   task automatic test_reset;
      rst = 1'b1; A = 2'b11; B = 2'b11; clear = 2'b00;
      tick(3);
      checks++; if (w_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt_w: got %h expected 0000", w_cnt); end
      checks++; if (s_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt_s: got %h expected 0000", s_cnt); end
      checks++; if (f_cnt !== 16'h0000) begin errors++; $display("FAIL reset_cnt_f: got %h expected 0000", f_cnt); end
      checks++; if ({w_cw, w_ccw, w_err, s_cw, s_ccw, s_err, f_cw, f_ccw, f_err} !== 18'h0) begin
         errors++; $display("FAIL reset_pulses: got %h expected 0", {w_cw, w_ccw, w_err, s_cw, s_ccw, s_err, f_cw, f_ccw, f_err});
      end
      rst = 1'b0;
      tick(HOLD);
      checks++; if ((n_f_cw[0] + n_f_ccw[0] + n_f_err[0]) !== 0) begin
         errors++; $display("FAIL idle_after_reset: got %0d pulses expected 0", n_f_cw[0] + n_f_ccw[0] + n_f_err[0]);
      end
   endtask

   // x1 clockwise detent on ch0, pulse latency measured from the final edge.
   task automatic test_x1_cw;
      int b_cw, b_ccw, first;
      b_cw = n_w_cw[0]; b_ccw = n_w_ccw[0];
      drive(0, 2'b01, HOLD); drive(0, 2'b00, HOLD); drive(0, 2'b10, HOLD);
      A[0] = 1'b1; B[0] = 1'b1;
      first = -1;
      for (int k = 1; k <= HOLD; k++) begin
         tick(1);
         if (w_cw[0] === 1'b1 && first < 0) first = k;
      end
      checks++; if (first !== DB + 3) begin errors++; $display("FAIL x1_cw_latency: got %0d expected %0d", first, DB + 3); end
      checks++; if (n_w_cw[0] - b_cw !== 1) begin errors++; $display("FAIL x1_cw_pulses: got %0d expected 1", n_w_cw[0] - b_cw); end
      checks++; if (n_w_ccw[0] - b_ccw !== 0) begin errors++; $display("FAIL x1_cw_no_ccw: got %0d expected 0", n_w_ccw[0] - b_ccw); end
      checks++; if (w_cnt[7:0] !== 8'h01) begin errors++; $display("FAIL x1_cw_count0: got %h expected 01", w_cnt[7:0]); end
      checks++; if (w_cnt[15:8] !== 8'h00) begin errors++; $display("FAIL x1_cw_count1_idle: got %h expected 00", w_cnt[15:8]); end
      checks++; if (s_cnt[7:0] !== 8'h01) begin errors++; $display("FAIL x1_cw_count0_sat: got %h expected 01", s_cnt[7:0]); end
   endtask

   // x1 counter-clockwise detent on ch1, then a jitter excursion that must not count.
   task automatic test_x1_ccw_jitter;
      int b_cw, b_ccw, b_err;
      b_cw = n_w_cw[1]; b_ccw = n_w_ccw[1];
      drive(1, 2'b10, HOLD); drive(1, 2'b00, HOLD); drive(1, 2'b01, HOLD); drive(1, 2'b11, HOLD);
      checks++; if (n_w_ccw[1] - b_ccw !== 1) begin errors++; $display("FAIL x1_ccw_pulses: got %0d expected 1", n_w_ccw[1] - b_ccw); end
      checks++; if (n_w_cw[1] - b_cw !== 0) begin errors++; $display("FAIL x1_ccw_no_cw: got %0d expected 0", n_w_cw[1] - b_cw); end
      checks++; if (w_cnt[15:8] !== 8'hFF) begin errors++; $display("FAIL x1_ccw_count1: got %h expected ff", w_cnt[15:8]); end
      checks++; if (w_cnt[7:0] !== 8'h01) begin errors++; $display("FAIL x1_ccw_count0_kept: got %h expected 01", w_cnt[7:0]); end
      b_cw = n_w_cw[1]; b_ccw = n_w_ccw[1]; b_err = n_w_err[1];
      drive(1, 2'b01, HOLD); drive(1, 2'b11, HOLD);
      checks++; if ((n_w_cw[1] - b_cw) + (n_w_ccw[1] - b_ccw) + (n_w_err[1] - b_err) !== 0) begin
         errors++; $display("FAIL jitter_pulses: got %0d expected 0", (n_w_cw[1] - b_cw) + (n_w_ccw[1] - b_ccw) + (n_w_err[1] - b_err));
      end
      checks++; if (w_cnt[15:8] !== 8'hFF) begin errors++; $display("FAIL jitter_count1: got %h expected ff", w_cnt[15:8]); end
   endtask

   // Debounce boundary, observed through the x4 instance which pulses on every accepted edge.
   task automatic test_bounce;
      int b_cw, b_ccw, b_wcw;
      b_cw = n_f_cw[0]; b_ccw = n_f_ccw[0];
      A[0] = 1'b0; tick(1);
      A[0] = 1'b1; tick(1);
      A[0] = 1'b0; tick(1);
      A[0] = 1'b1; tick(HOLD);
      checks++; if ((n_f_cw[0] - b_cw) + (n_f_ccw[0] - b_ccw) !== 0) begin
         errors++; $display("FAIL bounce_rejected: got %0d pulses expected 0", (n_f_cw[0] - b_cw) + (n_f_ccw[0] - b_ccw));
      end
      A[0] = 1'b0; tick(DB - 1);
      A[0] = 1'b1; tick(HOLD);
      checks++; if ((n_f_cw[0] - b_cw) + (n_f_ccw[0] - b_ccw) !== 0) begin
         errors++; $display("FAIL short_hold_rejected: got %0d pulses expected 0", (n_f_cw[0] - b_cw) + (n_f_ccw[0] - b_ccw));
      end
      b_wcw = n_w_cw[0];
      A[0] = 1'b0; tick(DB);
      A[0] = 1'b1; tick(HOLD);
      checks++; if (n_f_cw[0] - b_cw !== 1) begin errors++; $display("FAIL held_accept_cw: got %0d expected 1", n_f_cw[0] - b_cw); end
      checks++; if (n_f_ccw[0] - b_ccw !== 1) begin errors++; $display("FAIL held_accept_ccw: got %0d expected 1", n_f_ccw[0] - b_ccw); end
      checks++; if (n_w_cw[0] - b_wcw !== 0) begin errors++; $display("FAIL held_x1_no_step: got %0d expected 0", n_w_cw[0] - b_wcw); end
      checks++; if (w_cnt[7:0] !== 8'h01) begin errors++; $display("FAIL held_x1_count0: got %h expected 01", w_cnt[7:0]); end
   endtask

   // Drive ch0 up to +127, then one more detent: wrap to -128 vs saturate at +127.
   task automatic test_wrap_sat;
      int b_w, b_s;
      for (int i = 0; i < 126; i++) begin
         drive(0, 2'b01, 10); drive(0, 2'b00, 10); drive(0, 2'b10, 10); drive(0, 2'b11, 10);
      end
      checks++; if (w_cnt[7:0] !== 8'h7F) begin errors++; $display("FAIL at_max_wrap: got %h expected 7f", w_cnt[7:0]); end
      checks++; if (s_cnt[7:0] !== 8'h7F) begin errors++; $display("FAIL at_max_sat: got %h expected 7f", s_cnt[7:0]); end
      b_w = n_w_cw[0]; b_s = n_s_cw[0];
      drive(0, 2'b01, HOLD); drive(0, 2'b00, HOLD); drive(0, 2'b10, HOLD); drive(0, 2'b11, HOLD);
      checks++; if (w_cnt[7:0] !== 8'h80) begin errors++; $display("FAIL wrap_to_min: got %h expected 80", w_cnt[7:0]); end
      checks++; if (s_cnt[7:0] !== 8'h7F) begin errors++; $display("FAIL sat_hold_max: got %h expected 7f", s_cnt[7:0]); end
      checks++; if (n_w_cw[0] - b_w !== 1) begin errors++; $display("FAIL wrap_pulse: got %0d expected 1", n_w_cw[0] - b_w); end
      checks++; if (n_s_cw[0] - b_s !== 1) begin errors++; $display("FAIL sat_pulse: got %0d expected 1", n_s_cw[0] - b_s); end
   endtask

   // Illegal double-bit jump, then clear coinciding with a detent step.
   task automatic test_illegal_clear;
      int b_err, b_cw, b_ccw;
      b_err = n_w_err[0]; b_cw = n_w_cw[0]; b_ccw = n_w_ccw[0];
      drive(0, 2'b00, HOLD);
      checks++; if (n_w_err[0] - b_err !== 1) begin errors++; $display("FAIL illegal_err_pulse: got %0d expected 1", n_w_err[0] - b_err); end
      checks++; if ((n_w_cw[0] - b_cw) + (n_w_ccw[0] - b_ccw) !== 0) begin
         errors++; $display("FAIL illegal_no_dir: got %0d expected 0", (n_w_cw[0] - b_cw) + (n_w_ccw[0] - b_ccw));
      end
      checks++; if (w_cnt[7:0] !== 8'h80) begin errors++; $display("FAIL illegal_count_kept: got %h expected 80", w_cnt[7:0]); end
      drive(0, 2'b11, HOLD);
      checks++; if (n_w_err[0] - b_err !== 2) begin errors++; $display("FAIL illegal_return_err: got %0d expected 2", n_w_err[0] - b_err); end
      drive(0, 2'b01, HOLD); drive(0, 2'b00, HOLD); drive(0, 2'b10, HOLD);
      A[0] = 1'b1; B[0] = 1'b1;
      tick(DB + 2);
      clear[0] = 1'b1;
      tick(1);
      checks++; if (w_cw[0] !== 1'b1) begin errors++; $display("FAIL clear_step_pulse: got %b expected 1", w_cw[0]); end
      checks++; if (w_cnt[7:0] !== 8'h00) begin errors++; $display("FAIL clear_wins_wrap: got %h expected 00", w_cnt[7:0]); end
      checks++; if (s_cnt[7:0] !== 8'h00) begin errors++; $display("FAIL clear_wins_sat: got %h expected 00", s_cnt[7:0]); end
      checks++; if (w_cnt[15:8] !== 8'hFF) begin errors++; $display("FAIL clear_ch1_untouched: got %h expected ff", w_cnt[15:8]); end
      clear[0] = 1'b0;
      tick(HOLD - DB - 3);
      checks++; if (w_cnt[7:0] !== 8'h00) begin errors++; $display("FAIL clear_stays: got %h expected 00", w_cnt[7:0]); end
   endtask

   // x4 full CW cycle, then asynchronous reset while a pulse is high.
   task automatic test_x4_reset;
      int b_cw, b_ccw, b_err;
      rst = 1'b1; tick(2); rst = 1'b0; tick(2);
      b_cw = n_f_cw[0]; b_ccw = n_f_ccw[0];
      drive(0, 2'b01, HOLD); drive(0, 2'b00, HOLD); drive(0, 2'b10, HOLD); drive(0, 2'b11, HOLD);
      checks++; if (n_f_cw[0] - b_cw !== 4) begin errors++; $display("FAIL x4_cw_pulses: got %0d expected 4", n_f_cw[0] - b_cw); end
      checks++; if (n_f_ccw[0] - b_ccw !== 0) begin errors++; $display("FAIL x4_no_ccw: got %0d expected 0", n_f_ccw[0] - b_ccw); end
      checks++; if (f_cnt[7:0] !== 8'h04) begin errors++; $display("FAIL x4_count0: got %h expected 04", f_cnt[7:0]); end
      drive(0, 2'b01, HOLD);
      B[0] = 1'b0;
      tick(DB + 3);
      checks++; if (f_cw[0] !== 1'b1) begin errors++; $display("FAIL x4_pulse_before_rst: got %b expected 1", f_cw[0]); end
      checks++; if (f_cnt[7:0] !== 8'h06) begin errors++; $display("FAIL x4_count_before_rst: got %h expected 06", f_cnt[7:0]); end
      rst = 1'b1;
      #1;
      checks++; if ({f_cw, f_ccw, f_err} !== 6'h0) begin errors++; $display("FAIL async_rst_pulses: got %h expected 0", {f_cw, f_ccw, f_err}); end
      checks++; if (f_cnt !== 16'h0000) begin errors++; $display("FAIL async_rst_count: got %h expected 0000", f_cnt); end
      A[0] = 1'b1; B[0] = 1'b1;
      tick(5);
      rst = 1'b0;
      b_cw = n_f_cw[0]; b_ccw = n_f_ccw[0]; b_err = n_f_err[0];
      tick(30);
      checks++; if ((n_f_cw[0] - b_cw) + (n_f_ccw[0] - b_ccw) + (n_f_err[0] - b_err) !== 0) begin
         errors++; $display("FAIL post_rst_quiet: got %0d pulses expected 0", (n_f_cw[0] - b_cw) + (n_f_ccw[0] - b_ccw) + (n_f_err[0] - b_err));
      end
      checks++; if (f_cnt[7:0] !== 8'h00) begin errors++; $display("FAIL post_rst_count: got %h expected 00", f_cnt[7:0]); end
   endtask

   // Leaving reset with ch0 pins at 00 looks like an illegal 11 -> 00 jump.
   task automatic test_reset_raw00;
      int b_err0, b_err1, b_dir, b_werr;
      A[0] = 1'b0; B[0] = 1'b0;
      rst = 1'b1; tick(3); rst = 1'b0;
      b_err0 = n_f_err[0]; b_err1 = n_f_err[1]; b_dir = n_f_cw[0] + n_f_ccw[0]; b_werr = n_w_err[0];
      tick(HOLD);
      checks++; if (n_f_err[0] - b_err0 !== 1) begin errors++; $display("FAIL raw00_err: got %0d expected 1", n_f_err[0] - b_err0); end
      checks++; if (n_f_err[1] - b_err1 !== 0) begin errors++; $display("FAIL raw00_ch1_quiet: got %0d expected 0", n_f_err[1] - b_err1); end
      checks++; if ((n_f_cw[0] + n_f_ccw[0]) - b_dir !== 0) begin errors++; $display("FAIL raw00_no_dir: got %0d expected 0", (n_f_cw[0] + n_f_ccw[0]) - b_dir); end
      checks++; if (n_w_err[0] - b_werr !== 1) begin errors++; $display("FAIL raw00_err_x1: got %0d expected 1", n_w_err[0] - b_werr); end
      checks++; if (f_cnt !== 16'h0000) begin errors++; $display("FAIL raw00_count: got %h expected 0000", f_cnt); end
      drive(0, 2'b11, HOLD);
   endtask

   initial begin
      test_reset();
      test_x1_cw();
      test_x1_ccw_jitter();
      test_bounce();
      test_wrap_sat();
      test_illegal_clear();
      test_x4_reset();
      test_reset_raw00();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
